history_buffer_mp: RTL and testbench
====================================

Name: history_buffer_mp

Overview:
- Parametrised successor to the team's indexed lookback buffer.
- Stores the most recent DEPTH samples of DATA_WIDTH bits.
- Reads are non-destructive and indexed relative to the newest sample (index 0 = newest).
- Adds: overwrite or reject mode when full, a read-error flag for out-of-range indices, a registered valid, a flush input and a saturating drop counter. Sits between the byte/sample ingest stage and the pattern-match logic that looks back into recent history.

Parameters:
- DATA_WIDTH, 8, bits per stored sample.
- DEPTH, 256, number of entries; any value 2..2^ADDR_WIDTH; need not be a power of two.
- ADDR_WIDTH, 8, pointer/index width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- OVERWRITE, 0, 0 = writes rejected when full; 1 = oldest entry overwritten when full.
- DROP_WIDTH, 16, width of the drop counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all history.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  sample to write.
- wr_ready  out  1  write accepted this cycle if asserted with wr_en.
- rd_en  in  1  read request.
- rd_index  in  ADDR_WIDTH  lookback distance, 0 = newest.
- rd_data  out  DATA_WIDTH  registered read result.
- rd_valid  out  1  rd_data valid (1 cycle after rd_en).
- rd_err  out  1  index was out of range (with rd_valid).
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  ADDR_WIDTH+1  entries held.
- wr_ptr  out  ADDR_WIDTH  next write slot (debug).
- drop_cnt  out  DROP_WIDTH  rejected writes, saturating.

Behaviour:
- Reset: synchronous, active-high. All of the following are 0 on the cycle after rst is sampled high: rd_data, rd_valid, rd_err, count, wr_ptr, drop_cnt. empty=1, full=0. Memory contents are not reset.
- Reset mid-operation: any read in flight is dropped; rd_valid is 0 on the next cycle.
- Priority: rst > flush > write.
- wr_ready combinational: 1 when OVERWRITE=1, else !full.
- Accepted write:
  - mem[wr_ptr] <= wr_data.
  - wr_ptr advances by 1 and wraps DEPTH-1 -> 0.
  - count increments, saturating at DEPTH. In OVERWRITE=1 with full, count stays at DEPTH and the oldest entry is lost.
- Rejected write (OVERWRITE=0, full, wr_en=1): no state change except drop_cnt += 1, saturating at all-ones.
- flush: count <= 0 and wr_ptr <= 0 next cycle. A wr_en in the same cycle is discarded and not counted as a drop. drop_cnt is preserved.
- Read address: rd_addr = (wr_ptr - 1 - rd_index) mod DEPTH.
  - Computed by compare: if rd_index < wr_ptr, then wr_ptr-1-rd_index; else DEPTH+wr_ptr-1-rd_index.
  - Use ADDR_WIDTH+1 intermediate width; no reliance on natural 2^N wrap.
- Read latency: exactly 1 cycle.
  - Cycle N: rd_en sampled.
  - Cycle N+1: rd_valid=1; rd_data=mem[rd_addr] and rd_err=0, or rd_data=0 and rd_err=1.
  - rd_valid is 0 in any cycle not following an rd_en.
- Range check: rd_err=1 when rd_index >= count, including all reads while empty.
- Simultaneous read and write/flush in one cycle: the read sees pre-edge state (wr_ptr, count, mem). The sample written that cycle is not visible at index 0 until the next read.
- Back-to-back reads every cycle are supported; full throughput, no stall.
- No combinational path from rd_en/rd_index to rd_data.

Test Plan:
- DEPTH=4, OVERWRITE=0: reset, write 0x11,0x22,0x33; read idx 0,1,2,3 on consecutive cycles -> rd_data 0x33,0x22,0x11 with rd_err=0, then rd_err=1/rd_data=0 for idx 3; count=3.
- DEPTH=4, OVERWRITE=0: write 0xA0..0xA5 -> full=1 after 4 writes, wr_ready=0, drop_cnt=2; read idx 0 -> 0xA3.
- DEPTH=4, OVERWRITE=1: write 0xA0..0xA5 -> count=4, drop_cnt=0, wr_ptr=2; read idx 0..3 -> 0xA5,0xA4,0xA3,0xA2.
- DEPTH=5 (non-power-of-two): write 7 samples 1..7 with OVERWRITE=1 -> wr_ptr=2; read idx 2 -> 5, idx 4 -> 3 (wrap path).
- Same-cycle write 0x55 and read idx 0 after history {0x44} -> rd_data=0x44; next-cycle read idx 0 -> 0x55.
- flush with simultaneous wr_en after 3 writes -> count=0, empty=1, drop_cnt unchanged; read idx 0 -> rd_err=1. rst asserted during a read -> rd_valid=0 next cycle and all outputs at reset values.

Source files
------------

// File: rtl/history_buffer_mp.sv
//------------------------------------------------------------------------------
// Module   : history_buffer_mp
// Purpose  : Indexed lookback buffer of the newest DEPTH samples with
//            overwrite/reject mode and a saturating drop counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module history_buffer_mp #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 256,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned OVERWRITE  = 0,
   parameter int unsigned DROP_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ready,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_index,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_err,
   output logic                  empty,
   output logic                  full,
   output logic [ADDR_WIDTH:0]   count,
   output logic [ADDR_WIDTH-1:0] wr_ptr,
   output logic [DROP_WIDTH-1:0] drop_cnt
);

   localparam logic [ADDR_WIDTH:0]   c_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] c_LAST  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   c_ONE_X = (ADDR_WIDTH+1)'(1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH:0]   r_count;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [DROP_WIDTH-1:0] r_drop_cnt;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_valid;
   logic                  r_rd_err;

   logic                  w_full;
   logic                  w_wr_ready;
   logic                  w_wr_acc;
   logic                  w_wr_drop;
   logic [ADDR_WIDTH-1:0] w_ptr_next;
   logic [ADDR_WIDTH:0]   w_ptr_x;
   logic [ADDR_WIDTH:0]   w_idx_x;
   logic [ADDR_WIDTH:0]   w_addr_x;
   logic [ADDR_WIDTH-1:0] w_rd_addr;
   logic                  w_rd_oor;

   assign w_full     = (r_count == c_DEPTH);
   assign w_wr_ready = (OVERWRITE != 0) ? 1'b1 : !w_full;
   assign w_wr_acc   = wr_en & w_wr_ready & ~flush & ~rst;
   assign w_wr_drop  = wr_en & ~w_wr_ready & ~flush;
   assign w_ptr_next = (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;

   // Wrap by explicit compare so non-power-of-two depths index correctly.
   assign w_ptr_x = {1'b0, r_wr_ptr};
   assign w_idx_x = {1'b0, rd_index};

   always_comb begin
      w_addr_x = '0;
      if (w_idx_x < w_ptr_x) begin
         w_addr_x = w_ptr_x - c_ONE_X - w_idx_x;
      end else begin
         w_addr_x = c_DEPTH + w_ptr_x - c_ONE_X - w_idx_x;
      end
   end

   assign w_rd_addr = w_addr_x[ADDR_WIDTH-1:0];
   assign w_rd_oor  = (w_idx_x >= r_count);

   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_drop_cnt <= '0;
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_rd_err   <= 1'b0;
      end else begin
         r_rd_valid <= rd_en;
         r_rd_err   <= rd_en & w_rd_oor;
         if (rd_en) begin
            r_rd_data <= w_rd_oor ? '0 : r_mem[w_rd_addr];
         end

         if (flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
         end else if (w_wr_acc) begin
            r_wr_ptr <= w_ptr_next;
            if (r_count != c_DEPTH) begin
               r_count <= r_count + c_ONE_X;
            end
         end

         if (w_wr_drop && (r_drop_cnt != {DROP_WIDTH{1'b1}})) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
         end
      end
   end

   assign wr_ready = w_wr_ready;
   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign rd_err   = r_rd_err;
   assign empty    = (r_count == '0);
   assign full     = w_full;
   assign count    = r_count;
   assign wr_ptr   = r_wr_ptr;
   assign drop_cnt = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_history_buffer_mp.sv
//------------------------------------------------------------------------------
// Module   : tb_history_buffer_mp
// Purpose  : Directed bench driving three buffer configurations in lockstep.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_history_buffer_mp;

   logic       clk = 1'b0;
   logic       rst, flush, wr_en, rd_en;
   logic [7:0] wr_data;
   logic [2:0] rd_idx;

   // a_: DEPTH=4 reject, b_: DEPTH=4 overwrite, c_: DEPTH=5 overwrite
   wire        a_wr_ready, a_rd_valid, a_rd_err, a_empty, a_full;
   wire [7:0]  a_rd_data;
   wire [2:0]  a_count;
   wire [1:0]  a_wr_ptr;
   wire [15:0] a_drop;
   wire        b_wr_ready, b_rd_valid, b_rd_err, b_empty, b_full;
   wire [7:0]  b_rd_data;
   wire [2:0]  b_count;
   wire [1:0]  b_wr_ptr;
   wire [15:0] b_drop;
   wire        c_wr_ready, c_rd_valid, c_rd_err, c_empty, c_full;
   wire [7:0]  c_rd_data;
   wire [3:0]  c_count;
   wire [2:0]  c_wr_ptr;
   wire [15:0] c_drop;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   history_buffer_mp #(.DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .OVERWRITE(0), .DROP_WIDTH(16)) u_a (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .wr_ready(a_wr_ready), .rd_en(rd_en), .rd_index(rd_idx[1:0]),
      .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_err(a_rd_err),
      .empty(a_empty), .full(a_full), .count(a_count), .wr_ptr(a_wr_ptr), .drop_cnt(a_drop));

   history_buffer_mp #(.DATA_WIDTH(8), .DEPTH(4), .ADDR_WIDTH(2), .OVERWRITE(1), .DROP_WIDTH(16)) u_b (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .wr_ready(b_wr_ready), .rd_en(rd_en), .rd_index(rd_idx[1:0]),
      .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_err(b_rd_err),
      .empty(b_empty), .full(b_full), .count(b_count), .wr_ptr(b_wr_ptr), .drop_cnt(b_drop));

   history_buffer_mp #(.DATA_WIDTH(8), .DEPTH(5), .ADDR_WIDTH(3), .OVERWRITE(1), .DROP_WIDTH(16)) u_c (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
      .wr_ready(c_wr_ready), .rd_en(rd_en), .rd_index(rd_idx),
      .rd_data(c_rd_data), .rd_valid(c_rd_valid), .rd_err(c_rd_err),
      .empty(c_empty), .full(c_full), .count(c_count), .wr_ptr(c_wr_ptr), .drop_cnt(c_drop));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wr(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic rd(input logic [2:0] idx);
      rd_en  = 1'b1;
      rd_idx = idx;
      tick();
      rd_en  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      wr_data = 8'h00; rd_idx = 3'd0;
      tick();
      do_reset();

      check_eq("rst_count",  32'(a_count),    0);
      check_eq("rst_empty",  32'(a_empty),    1);
      check_eq("rst_full",   32'(a_full),     0);
      check_eq("rst_wrptr",  32'(a_wr_ptr),   0);
      check_eq("rst_drop",   32'(a_drop),     0);
      check_eq("rst_rvalid", 32'(a_rd_valid), 0);
      check_eq("rst_rdata",  32'(a_rd_data),  0);

      // Three samples, then four back-to-back reads
      wr(8'h11); wr(8'h22); wr(8'h33);
      check_eq("t1_count", 32'(a_count), 3);
      rd(3'd0);
      check_eq("t1_v0", 32'(a_rd_valid), 1);
      check_eq("t1_d0", 32'(a_rd_data), 32'h33);
      check_eq("t1_e0", 32'(a_rd_err), 0);
      rd(3'd1);
      check_eq("t1_d1", 32'(a_rd_data), 32'h22);
      rd(3'd2);
      check_eq("t1_d2", 32'(a_rd_data), 32'h11);
      check_eq("t1_e2", 32'(a_rd_err), 0);
      rd(3'd3);
      check_eq("t1_v3", 32'(a_rd_valid), 1);
      check_eq("t1_e3", 32'(a_rd_err), 1);
      check_eq("t1_d3", 32'(a_rd_data), 0);
      tick();
      check_eq("t1_vidle", 32'(a_rd_valid), 0);

      // Six writes: reject mode drops two, overwrite mode keeps newest four
      do_reset();
      for (int i = 0; i < 4; i++) wr(8'hA0 + 8'(i));
      check_eq("t2_full",  32'(a_full), 1);
      check_eq("t2_wrdy",  32'(a_wr_ready), 0);
      check_eq("t2_bwrdy", 32'(b_wr_ready), 1);
      wr(8'hA4); wr(8'hA5);
      check_eq("t2_drop",   32'(a_drop), 2);
      check_eq("t2_count",  32'(a_count), 4);
      check_eq("t2_aptr",   32'(a_wr_ptr), 0);
      check_eq("t2_bcount", 32'(b_count), 4);
      check_eq("t2_bdrop",  32'(b_drop), 0);
      check_eq("t2_bptr",   32'(b_wr_ptr), 2);
      rd(3'd0);
      check_eq("t2_ad0", 32'(a_rd_data), 32'hA3);
      check_eq("t2_bd0", 32'(b_rd_data), 32'hA5);
      rd(3'd1);
      check_eq("t2_bd1", 32'(b_rd_data), 32'hA4);
      rd(3'd2);
      check_eq("t2_bd2", 32'(b_rd_data), 32'hA3);
      rd(3'd3);
      check_eq("t2_bd3", 32'(b_rd_data), 32'hA2);
      check_eq("t2_be3", 32'(b_rd_err), 0);

      // Flush with a write that would otherwise be a drop
      flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
      tick();
      flush = 1'b0; wr_en = 1'b0;
      check_eq("fl_count", 32'(a_count), 0);
      check_eq("fl_empty", 32'(a_empty), 1);
      check_eq("fl_drop",  32'(a_drop), 2);
      check_eq("fl_ptr",   32'(a_wr_ptr), 0);
      check_eq("fl_bcnt",  32'(b_count), 0);
      rd(3'd0);
      check_eq("fl_err",  32'(a_rd_err), 1);
      check_eq("fl_berr", 32'(b_rd_err), 1);

      // Same-cycle write and read see the pre-edge history
      wr(8'h44);
      wr_en = 1'b1; wr_data = 8'h55; rd_en = 1'b1; rd_idx = 3'd0;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      check_eq("sc_d0", 32'(a_rd_data), 32'h44);
      rd(3'd0);
      check_eq("sc_d1", 32'(a_rd_data), 32'h55);
      check_eq("sc_cnt", 32'(a_count), 2);

      // Non-power-of-two depth across the wrap
      do_reset();
      for (int i = 1; i <= 7; i++) wr(8'(i));
      check_eq("t3_ptr",   32'(c_wr_ptr), 2);
      check_eq("t3_count", 32'(c_count), 5);
      check_eq("t3_full",  32'(c_full), 1);
      rd(3'd0);
      check_eq("t3_d0", 32'(c_rd_data), 7);
      rd(3'd2);
      check_eq("t3_d2", 32'(c_rd_data), 5);
      rd(3'd4);
      check_eq("t3_d4", 32'(c_rd_data), 3);
      check_eq("t3_e4", 32'(c_rd_err), 0);

      // Reset coinciding with a read
      rd_en = 1'b1; rd_idx = 3'd0; rst = 1'b1;
      tick();
      rd_en = 1'b0; rst = 1'b0;
      check_eq("rr_valid", 32'(c_rd_valid), 0);
      check_eq("rr_data",  32'(c_rd_data), 0);
      check_eq("rr_err",   32'(c_rd_err), 0);
      check_eq("rr_count", 32'(c_count), 0);
      check_eq("rr_ptr",   32'(c_wr_ptr), 0);
      check_eq("rr_empty", 32'(c_empty), 1);
      check_eq("rr_full",  32'(c_full), 0);
      check_eq("rr_adrop", 32'(a_drop), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
